// File: rtl/r5p_gpr_wb_ctl.sv
// GPR write-side controller: clears every register after reset, then merges ALU and LSU
// writebacks (LSU has priority) onto the single GPR write port through one register stage.
module r5p_gpr_wb_ctl #(
    parameter int unsigned AW   = 5,
    parameter int unsigned XLEN = 32,
    parameter bit          CLR  = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en0,
    input  logic            alu_vld,
    output logic            alu_rdy,
    input  logic [AW-1:0]   alu_adr,
    input  logic [XLEN-1:0] alu_dat,
    input  logic            lsu_vld,
    output logic            lsu_rdy,
    input  logic [AW-1:0]   lsu_adr,
    input  logic [XLEN-1:0] lsu_dat,
    output logic            e_rd,
    output logic [AW-1:0]   a_rd,
    output logic [XLEN-1:0] d_rd,
    output logic            init
);

    localparam logic [0:0] StClear = 1'b0;
    localparam logic [0:0] StRun   = 1'b1;

    localparam logic [AW-1:0] CntOne = {{(AW-1){1'b0}}, 1'b1};

    logic [0:0]      state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            e_rd_q, e_rd_d;
    logic [AW-1:0]   a_rd_q, a_rd_d;
    logic [XLEN-1:0] d_rd_q, d_rd_d;

    logic            run;
    logic            wr_vld;
    logic [AW-1:0]   wr_adr;
    logic [XLEN-1:0] wr_dat;
    logic            wr_ok;

    assign run     = (state_q == StRun);
    assign init    = ~run;
    assign lsu_rdy = run;
    assign alu_rdy = run & ~lsu_vld;

    // LSU wins whenever it is valid, so the ALU transfer is implied by alu_vld & ~lsu_vld.
    assign wr_vld = lsu_vld | alu_vld;
    assign wr_adr = lsu_vld ? lsu_adr : alu_adr;
    assign wr_dat = lsu_vld ? lsu_dat : alu_dat;
    assign wr_ok  = wr_vld & (en0 | (|wr_adr));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        e_rd_d  = 1'b0;
        a_rd_d  = a_rd_q;
        d_rd_d  = d_rd_q;
        if (state_q == StClear) begin
            e_rd_d = 1'b1;
            a_rd_d = cnt_q;
            d_rd_d = '0;
            cnt_d  = cnt_q + CntOne;
            if (&cnt_q) begin
                state_d = StRun;
            end
        end else if (wr_ok) begin
            e_rd_d = 1'b1;
            a_rd_d = wr_adr;
            d_rd_d = wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLR ? StClear : StRun;
            cnt_q   <= '0;
            e_rd_q  <= 1'b0;
            a_rd_q  <= '0;
            d_rd_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            e_rd_q  <= e_rd_d;
            a_rd_q  <= a_rd_d;
            d_rd_q  <= d_rd_d;
        end
    end

    assign e_rd = e_rd_q;
    assign a_rd = a_rd_q;
    assign d_rd = d_rd_q;

endmodule

// File: tb/tb_r5p_gpr_wb_ctl.sv
// Directed bench for r5p_gpr_wb_ctl: clear sequence, arbitration vectors, x0 filtering,
// LSU streaming and reset during clear.
module tb_r5p_gpr_wb_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en0;
    logic        alu_vld, alu_rdy;
    logic [4:0]  alu_adr;
    logic [31:0] alu_dat;
    logic        lsu_vld, lsu_rdy;
    logic [4:0]  lsu_adr;
    logic [31:0] lsu_dat;
    logic        e_rd;
    logic [4:0]  a_rd;
    logic [31:0] d_rd;
    logic        init;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    r5p_gpr_wb_ctl #(
        .AW   (5),
        .XLEN (32),
        .CLR  (1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en0     (en0),
        .alu_vld (alu_vld),
        .alu_rdy (alu_rdy),
        .alu_adr (alu_adr),
        .alu_dat (alu_dat),
        .lsu_vld (lsu_vld),
        .lsu_rdy (lsu_rdy),
        .lsu_adr (lsu_adr),
        .lsu_dat (lsu_dat),
        .e_rd    (e_rd),
        .a_rd    (a_rd),
        .d_rd    (d_rd),
        .init    (init)
    );

    typedef struct {
        logic        alu_vld;
        logic [4:0]  alu_adr;
        logic [31:0] alu_dat;
        logic        lsu_vld;
        logic [4:0]  lsu_adr;
        logic [31:0] lsu_dat;
        logic        en0;
        logic        exp_alu_rdy;
        logic        exp_lsu_rdy;
        logic        exp_e_rd;
        logic        chk_ad;
        logic [4:0]  exp_a_rd;
        logic [31:0] exp_d_rd;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expects the first clear edge to be the next one.
    task automatic clear_seq();
        for (int k = 0; k < 32; k++) begin
            tick();
            chk("clr_e_rd", {31'b0, e_rd}, 32'd1);
            chk("clr_a_rd", {27'b0, a_rd}, k);
            chk("clr_d_rd", d_rd, 32'd0);
            if (k < 31) begin
                chk("clr_init", {31'b0, init}, 32'd1);
                chk("clr_alu_rdy", {31'b0, alu_rdy}, 32'd0);
                chk("clr_lsu_rdy", {31'b0, lsu_rdy}, 32'd0);
            end
        end
        chk("run_init", {31'b0, init}, 32'd0);
        tick();
        chk("post_clr_e_rd", {31'b0, e_rd}, 32'd0);
    endtask

    initial begin
        //          alu_v adr    dat            lsu_v adr    dat            en0   ardy  lrdy  e     chkad a      d
        vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF};
        vecs[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 5'd3, 32'h1111,     1'b1, 5'd7, 32'h2222,     1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 32'h2222};
        vecs[3] = '{1'b1, 5'd3, 32'h1111,     1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 32'h1111};
        vecs[4] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
        vecs[5] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 32'hFFFFFFFF};
        vecs[6] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
        vecs[7] = '{1'b1, 5'd9, 32'h0BADF00D, 1'b1, 5'd31, 32'hCAFEF00D, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd31, 32'hCAFEF00D};
        vecs[8] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd12, 32'h5A5A5A5A, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd12, 32'h5A5A5A5A};

        rst = 1'b1; en0 = 1'b0;
        alu_vld = 1'b0; alu_adr = '0; alu_dat = '0;
        lsu_vld = 1'b0; lsu_adr = '0; lsu_dat = '0;

        tick();
        tick();
        chk("rst_e_rd", {31'b0, e_rd}, 32'd0);
        chk("rst_a_rd", {27'b0, a_rd}, 32'd0);
        chk("rst_d_rd", d_rd, 32'd0);
        chk("rst_init", {31'b0, init}, 32'd1);
        chk("rst_alu_rdy", {31'b0, alu_rdy}, 32'd0);
        chk("rst_lsu_rdy", {31'b0, lsu_rdy}, 32'd0);
        rst = 1'b0;
        clear_seq();

        for (int i = 0; i < 9; i++) begin
            alu_vld = vecs[i].alu_vld; alu_adr = vecs[i].alu_adr; alu_dat = vecs[i].alu_dat;
            lsu_vld = vecs[i].lsu_vld; lsu_adr = vecs[i].lsu_adr; lsu_dat = vecs[i].lsu_dat;
            en0     = vecs[i].en0;
            #1;
            chk($sformatf("v%0d_alu_rdy", i), {31'b0, alu_rdy}, {31'b0, vecs[i].exp_alu_rdy});
            chk($sformatf("v%0d_lsu_rdy", i), {31'b0, lsu_rdy}, {31'b0, vecs[i].exp_lsu_rdy});
            tick();
            chk($sformatf("v%0d_e_rd", i), {31'b0, e_rd}, {31'b0, vecs[i].exp_e_rd});
            if (vecs[i].chk_ad) begin
                chk($sformatf("v%0d_a_rd", i), {27'b0, a_rd}, {27'b0, vecs[i].exp_a_rd});
                chk($sformatf("v%0d_d_rd", i), d_rd, vecs[i].exp_d_rd);
            end
        end
        alu_vld = 1'b0; lsu_vld = 1'b0; en0 = 1'b0;
        tick();
        chk("idle_e_rd", {31'b0, e_rd}, 32'd0);

        // LSU stream while the ALU stays valid; the ALU write lands right after the stream.
        alu_vld = 1'b1; alu_adr = 5'd2; alu_dat = 32'h0000A5A5;
        for (int i = 1; i <= 4; i++) begin
            lsu_vld = 1'b1; lsu_adr = i[4:0]; lsu_dat = 32'h1000 + i;
            #1;
            chk("strm_alu_rdy", {31'b0, alu_rdy}, 32'd0);
            chk("strm_lsu_rdy", {31'b0, lsu_rdy}, 32'd1);
            tick();
            chk("strm_e_rd", {31'b0, e_rd}, 32'd1);
            chk("strm_a_rd", {27'b0, a_rd}, i);
            chk("strm_d_rd", d_rd, 32'h1000 + i);
        end
        lsu_vld = 1'b0;
        #1;
        chk("strm_alu_go", {31'b0, alu_rdy}, 32'd1);
        tick();
        chk("strm_alu_e_rd", {31'b0, e_rd}, 32'd1);
        chk("strm_alu_a_rd", {27'b0, a_rd}, 32'd2);
        chk("strm_alu_d_rd", d_rd, 32'h0000A5A5);
        alu_vld = 1'b0;
        tick();
        chk("strm_end_e_rd", {31'b0, e_rd}, 32'd0);

        // Reset while index 10 is on the write port, then a full clear again.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k <= 10; k++) tick();
        chk("mid_a_rd", {27'b0, a_rd}, 32'd10);
        rst = 1'b1;
        tick();
        chk("mid_rst_e_rd", {31'b0, e_rd}, 32'd0);
        chk("mid_rst_init", {31'b0, init}, 32'd1);
        rst = 1'b0;
        clear_seq();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
